unioperand_sequencer: RTL and testbench

Control sequencer for the unioperand (accumulator) microarchitecture: the block that drives the 5-bit program counter's `load`/`inc` controls and consumes its `out` value. It runs a fetch–decode–execute state machine over a synchronous-read unified memory. It holds the instruction register and issues memory, accumulator and ALU strobes, one instruction at a time.

---
 rtl/unioperand_sequencer_if.sv | 31 +++
 rtl/unioperand_sequencer.sv | 122 ++++++++++++
 tb/tb_unioperand_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unioperand_sequencer_if.sv
// unioperand_sequencer_if
// Bundles the sequencer's control/status signals toward the program counter,
// unified memory and accumulator. The sequencer uses the master modport; the
// datapath (or a testbench standing in for it) uses the slave modport.
interface unioperand_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] mem_rdata;
  logic              acc_zero;
  logic              pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              acc_load;
  logic [1:0]        alu_op;
  logic              halted;

  modport master (
    input  start, pc, mem_rdata, acc_zero,
    output pc_inc, pc_load, pc_target, mem_addr, mem_we, acc_load, alu_op, halted
  );

  modport slave (
    output start, pc, mem_rdata, acc_zero,
    input  pc_inc, pc_load, pc_target, mem_addr, mem_we, acc_load, alu_op, halted
  );
endinterface

// File: rtl/unioperand_sequencer.sv
// unioperand_sequencer
// Fetch-decode-execute control for the accumulator machine. Holds the
// instruction register and issues PC, memory, accumulator and ALU strobes,
// one instruction at a time, over a synchronous-read unified memory.
// Build option: define SEQ_COND_BRANCH_EN to make opcode 110 a JZ (branch on
// acc_zero); otherwise opcode 110 behaves as NOP and acc_zero is ignored.
module unioperand_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 3
) (
  input logic                    clk,
  input logic                    rst,
  unioperand_sequencer_if.master bus
);

  localparam int INSTR_W = OPC_W + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT,
    OP_LDA,
    OP_STA,
    OP_ADD,
    OP_SUB,
    OP_JMP,
    OP_JZ,
    OP_NOP
  } opcode_t;

  state_t               state;
  state_t               state_nx;
  logic [INSTR_W-1:0]   ir;
  opcode_t              opc;
  logic [ADDR_W-1:0]    ir_addr;

  assign opc     = opcode_t'(ir[INSTR_W-1 -: OPC_W]);
  assign ir_addr = ir[ADDR_W-1:0];

  // State register and instruction register; IR captures the fetched word in DECODE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) ir <= bus.mem_rdata;
    end
  end

  // Next-state and Moore strobe decode from the current state and IR.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nx      = state;
    bus.pc_inc    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_target = ir_addr;  // zero after reset because IR is cleared
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.acc_load  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.halted    = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        bus.halted = 1'b1;
        if (bus.start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_addr = bus.pc;
        state_nx     = S_DECODE;
      end
      S_DECODE: begin
        bus.pc_inc = 1'b1;
        state_nx   = S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (opc)
          OP_HLT: state_nx = S_HALT;
          OP_LDA, OP_ADD, OP_SUB: begin
            bus.mem_addr = ir_addr;
            state_nx     = S_WB;
          end
          OP_STA: begin
            bus.mem_addr = ir_addr;
            bus.mem_we   = 1'b1;
          end
          // The DECODE increment has already landed, so this load wins.
          OP_JMP: bus.pc_load = 1'b1;
`ifdef SEQ_COND_BRANCH_EN
          OP_JZ:  bus.pc_load = bus.acc_zero;
`else
          OP_JZ:  ;  // executes as NOP in this build
`endif
          default: ;  // NOP
        endcase
      end
      S_WB: begin
        bus.acc_load = 1'b1;
        case (opc)
          OP_ADD:  bus.alu_op = 2'b01;
          OP_SUB:  bus.alu_op = 2'b10;
          default: bus.alu_op = 2'b00;
        endcase
        state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_unioperand_sequencer.sv
// tb_unioperand_sequencer
// Drives the sequencer with a behavioural PC counter, memory and accumulator,
// and compares every cycle's strobes against an instruction-level reference
// model that expands each executed instruction into its expected cycles.
module tb_unioperand_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unioperand_sequencer_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  unioperand_sequencer #(.ADDR_W(5), .OPC_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic [4:0] pc_target;
    logic [4:0] mem_addr;
    logic       mem_we;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       halted;
  } obs_t;

  int checks = 0;
  int errors = 0;

  obs_t       exp_q[$];
  obs_t       care_q[$];
  logic [7:0] prog[32];
  logic [7:0] env_mem[32];
  logic [7:0] m_mem[32];
  logic [7:0] env_acc, m_acc;
  logic [4:0] env_pc, m_pc;
  bit         m_halted;

  function automatic obs_t sample();
    obs_t o;
    o.pc_inc    = bus.pc_inc;
    o.pc_load   = bus.pc_load;
    o.pc_target = bus.pc_target;
    o.mem_addr  = bus.mem_addr;
    o.mem_we    = bus.mem_we;
    o.acc_load  = bus.acc_load;
    o.alu_op    = bus.alu_op;
    o.halted    = bus.halted;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t expv, input obs_t care);
    logic [$bits(obs_t)-1:0] g, e, m;
    g = got; e = expv; m = care;
    checks++;
    assert ((g & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (care mask %h)", tag, g & m, e & m, m);
    end
  endtask

  task automatic push(input obs_t e, input bit care_tgt, input bit care_addr, input bit care_op);
    obs_t m;
    m = '1;
    if (!care_tgt)  m.pc_target = '0;
    if (!care_addr) m.mem_addr  = '0;
    if (!care_op)   m.alu_op    = '0;
    exp_q.push_back(e);
    care_q.push_back(m);
  endtask

  // Resting (IDLE/HALT) cycle: halted, no strobes.
  task automatic push_rest(input bit care_tgt);
    obs_t e;
    e = '0;
    e.halted = 1'b1;
    push(e, care_tgt, 1'b1, 1'b1);
  endtask

  // Instruction-level model: execute one instruction and append its cycles.
  task automatic model_instr();
    logic [7:0] ins;
    logic [2:0] op;
    logic [4:0] a;
    obs_t e;
    ins = m_mem[m_pc];
    op  = ins[7:5];
    a   = ins[4:0];
    e = '0; e.mem_addr = m_pc; push(e, 0, 1, 0);   // fetch
    e = '0; e.pc_inc = 1'b1;  push(e, 0, 0, 0);    // decode
    m_pc = m_pc + 5'd1;
    e = '0;
    case (op)
      3'd0: begin push(e, 0, 0, 0); m_halted = 1'b1; end
      3'd1, 3'd3, 3'd4: begin
        e.mem_addr = a; push(e, 0, 1, 0);
        e = '0; e.acc_load = 1'b1;
        e.alu_op = (op == 3'd1) ? 2'b00 : (op == 3'd3) ? 2'b01 : 2'b10;
        push(e, 0, 0, 1);
        if (op == 3'd1)      m_acc = m_mem[a];
        else if (op == 3'd3) m_acc = m_acc + m_mem[a];
        else                 m_acc = m_acc - m_mem[a];
      end
      3'd2: begin e.mem_addr = a; e.mem_we = 1'b1; push(e, 0, 1, 0); m_mem[a] = m_acc; end
      3'd5: begin e.pc_load = 1'b1; e.pc_target = a; push(e, 1, 0, 0); m_pc = a; end
      3'd6: begin
`ifdef SEQ_COND_BRANCH_EN
        if (m_acc == 8'h00) begin e.pc_load = 1'b1; e.pc_target = a; m_pc = a; end
`endif
        push(e, e.pc_load, 0, 0);
      end
      default: push(e, 0, 0, 0);
    endcase
  endtask

  task automatic drive_env();
    bus.pc       = env_pc;
    bus.acc_zero = (env_acc == 8'h00);
  endtask

  // One clock cycle: compare outputs, apply inputs, let the environment react.
  task automatic cycle(input logic st, input logic r, input string tag);
    obs_t got, e, m;
    got = sample();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = care_q.pop_front();
      check(tag, got, e, m);
    end
    bus.start = st;
    rst = r;
    @(posedge clk);
    #1;
    if (got.acc_load) begin
      case (got.alu_op)
        2'b00:   env_acc = bus.mem_rdata;
        2'b01:   env_acc = env_acc + bus.mem_rdata;
        2'b10:   env_acc = env_acc - bus.mem_rdata;
        default: ;
      endcase
    end
    bus.mem_rdata = env_mem[got.mem_addr];
    if (got.mem_we) env_mem[got.mem_addr] = env_acc;
    if (got.pc_load)     env_pc = got.pc_target;
    else if (got.pc_inc) env_pc = env_pc + 5'd1;
    drive_env();
    #1;
  endtask

  task automatic reset_models();
    exp_q.delete();
    care_q.delete();
    env_pc = '0; env_acc = '0; m_pc = '0; m_acc = '0;
    m_halted = 1'b1;
    for (int i = 0; i < 32; i++) begin env_mem[i] = prog[i]; m_mem[i] = prog[i]; end
    drive_env();
  endtask

  task automatic hard_reset(input int n, input logic st);
    rst = 1'b1;
    bus.start = st;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    reset_models();
    #1;
  endtask

  // Assert reset in whatever cycle the machine is in, then expect IDLE with IR cleared.
  task automatic abort(input logic st, input string tag);
    if (exp_q.size() == 0) begin
      if (m_halted) push_rest(1'b0);
      else model_instr();
    end
    cycle(st, 1'b1, tag);
    rst = 1'b0;
    reset_models();
    for (int i = 0; i < 2; i++) begin push_rest(1'b1); cycle(1'b0, 1'b0, "after_reset"); end
  endtask

  task automatic go(input string tag);
    push_rest(1'b0);
    cycle(1'b1, 1'b0, tag);
    m_halted = 1'b0;
  endtask

  // Run until the model halts or the cycle budget expires; start toggles at random.
  task automatic run(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (n < max_cycles) begin
      if (exp_q.size() == 0) begin
        if (m_halted) break;
        model_instr();
      end
      cycle(logic'($urandom_range(0, 1)), 1'b0, tag);
      n++;
    end
  endtask

  task automatic rest_cycles(input int k, input string tag);
    repeat (k) begin push_rest(1'b0); cycle(1'b0, 1'b0, tag); end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.pc = '0; bus.mem_rdata = '0; bus.acc_zero = 1'b1;

    // Reset then idle.
    clear_prog();
    hard_reset(2, 1'b0);
    for (int i = 0; i < 10; i++) begin push_rest(1'b1); cycle(1'b0, 1'b0, "idle"); end
    // Reset and start together: reset wins.
    push_rest(1'b1); cycle(1'b1, 1'b1, "rst_start");
    rst = 1'b0;
    push_rest(1'b1); cycle(1'b0, 1'b0, "rst_start_idle");

    // LDA 5 then HLT.
    clear_prog(); prog[0] = 8'h25; prog[5] = 8'h3C;
    hard_reset(1, 1'b0);
    go("lda_start"); run(40, "lda"); rest_cycles(3, "lda_halt");

    // JMP 17 from pc=3.
    clear_prog(); prog[0] = 8'hE0; prog[1] = 8'hE0; prog[2] = 8'hE0; prog[3] = 8'hB1;
    hard_reset(1, 1'b0);
    go("jmp_start"); run(40, "jmp"); rest_cycles(2, "jmp_halt");

    // JZ 9 with acc zero.
    clear_prog(); prog[0] = 8'hC9;
    hard_reset(1, 1'b0);
    go("jz1_start"); run(40, "jz_taken"); rest_cycles(2, "jz1_halt");

    // JZ 9 with acc non-zero.
    clear_prog(); prog[0] = 8'h2A; prog[10] = 8'h07; prog[1] = 8'hC9;
    hard_reset(1, 1'b0);
    go("jz0_start"); run(40, "jz_not_taken"); rest_cycles(2, "jz0_halt");

    // STA 31, HLT, resume, LDA 31 reads the stored value.
    clear_prog(); prog[0] = 8'h2A; prog[10] = 8'h5A; prog[1] = 8'h5F; prog[3] = 8'h3F;
    hard_reset(1, 1'b0);
    go("sta_start"); run(40, "sta"); rest_cycles(3, "sta_halt");
    go("resume"); run(40, "resume_run"); rest_cycles(2, "resume_halt");

    // Reset in the WB cycle of ADD.
    clear_prog(); prog[0] = 8'h6A; prog[10] = 8'h03;
    hard_reset(1, 1'b0);
    go("add_start"); model_instr();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "add");
    abort(1'b0, "add_wb");

    // Random programs, either halting (then resumed) or cut short by reset.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      hard_reset(1, 1'b0);
      go("rnd_start");
      run($urandom_range(5, 120), "rnd");
      if (exp_q.size() == 0 && m_halted) begin
        rest_cycles(2, "rnd_halt");
        go("rnd_resume");
        run($urandom_range(5, 60), "rnd_resumed");
      end
      abort(logic'($urandom_range(0, 1)), "rnd_abort");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
